// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - player controls and result display bundle for reaction_timer
interface reaction_timer_if;
    logic       start;
    logic       react;
    logic       led_go;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       false_start;
    logic       overflow;
    logic       busy;

    modport master (
        output start, react,
        input  led_go, digit3, digit2, digit1, digit0, false_start, overflow, busy
    );

    modport slave (
        input  start, react,
        output led_go, digit3, digit2, digit1, digit0, false_start, overflow, busy
    );
endinterface

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - random-delay go lamp followed by a 4-digit BCD millisecond count
module reaction_timer #(
    parameter int CLK_PER_MS   = 100000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic            clk,
    input  logic            rst,
    reaction_timer_if.slave io
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + 2048);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

    typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FALSE} state_t;
    state_t state, state_next;

    logic [15:0]     lfsr;
    logic [PW-1:0]   prescaler;
    logic [DW-1:0]   delay_ms;
    logic [3:0][3:0] cnt;
    logic [3:0][3:0] cnt_inc;
    logic            go_q, busy_q, false_q, ovf_q;
    logic            ms_tick, at_max, inc_carry;
    logic            load_round, count_inc, set_false, set_ovf;

    assign ms_tick = (prescaler == PRE_LAST);
    assign at_max  = (cnt == 16'h9999);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // react outranks a coincident tick in both WAIT and GO
    always_comb begin
        state_next = state;
        load_round = 1'b0;
        count_inc  = 1'b0;
        set_false  = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            IDLE, DONE, FALSE: begin
                if (io.start) begin
                    state_next = WAIT;
                    load_round = 1'b1;
                end
            end
            WAIT: begin
                if (io.react) begin
                    state_next = FALSE;
                    set_false  = 1'b1;
                end else if (ms_tick && delay_ms == DW'(1)) begin
                    state_next = GO;
                end
            end
            GO: begin
                if (io.react) begin
                    state_next = DONE;
                end else if (ms_tick) begin
                    if (at_max) begin
                        set_ovf    = 1'b1;
                        state_next = DONE;
                    end else begin
                        count_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ripple decimal carry from the ones digit upward
    always_comb begin
        cnt_inc   = cnt;
        inc_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (cnt[i] == 4'd9) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    inc_carry  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= 16'hACE1;
            prescaler <= '0;
            delay_ms  <= '0;
            cnt       <= '0;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            false_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            // prescaler restarts on every state change so WAIT and GO each begin on a full ms
            if (state_next != state || (state != WAIT && state != GO) || ms_tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + PW'(1);

            if (load_round)
                delay_ms <= DW'(MIN_DELAY_MS) + DW'(lfsr[10:0]);
            else if (state == WAIT && ms_tick)
                delay_ms <= delay_ms - DW'(1);

            if (load_round)     cnt <= '0;
            else if (count_inc) cnt <= cnt_inc;

            if (load_round)     false_q <= 1'b0;
            else if (set_false) false_q <= 1'b1;

            if (load_round)   ovf_q <= 1'b0;
            else if (set_ovf) ovf_q <= 1'b1;

            go_q   <= (state_next == GO);
            busy_q <= (state_next == WAIT) || (state_next == GO);
        end
    end

    assign io.led_go      = go_q;
    assign io.busy        = busy_q;
    assign io.false_start = false_q;
    assign io.overflow    = ovf_q;
    assign io.digit3      = cnt[3];
    assign io.digit2      = cnt[2];
    assign io.digit1      = cnt[1];
    assign io.digit0      = cnt[0];
endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter CLK_PER_MS, default 100000, SHALL set the clk cycles per millisecond tick.
REQ-002 Parameter MIN_DELAY_MS, default 1000, SHALL set the minimum random wait before the go signal, in ms.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL be a single-cycle pulse, already debounced, that arms a round.
REQ-006 react  input  1  SHALL be a single-cycle pulse, already debounced, from the player's button.
REQ-007 led_go  output  1  SHALL be the go stimulus, high only in state GO.
REQ-008 digit3, digit2, digit1, digit0  output  4 each  SHALL be the BCD thousands, hundreds, tens and ones of the reaction time in ms, feeding the 7-segment display multiplexer left to right.
REQ-009 false_start  output  1  SHALL flag a round ended by react during WAIT.
REQ-010 overflow  output  1  SHALL flag a round whose count saturated at 9999.
REQ-011 busy  output  1  SHALL be high in WAIT and GO.

Function
REQ-012 States SHALL be IDLE, WAIT, GO, DONE and FALSE.
REQ-013 A 16-bit Fibonacci LFSR SHALL advance every cycle in every state, using polynomial x^16+x^14+x^13+x^11+1; it SHALL never hold zero.
REQ-014 On start in IDLE, DONE or FALSE, the block SHALL load delay_ms = MIN_DELAY_MS + lfsr[10:0] (range MIN..MIN+2047), clear all digits and flags, clear the prescaler, and enter WAIT on the next cycle.
REQ-015 The prescaler SHALL count 0..CLK_PER_MS-1, SHALL emit ms_tick on the terminal count, and SHALL be cleared on entry to WAIT and to GO.
REQ-016 In WAIT, each ms_tick SHALL decrement delay_ms; when a tick finds delay_ms==1, the block SHALL enter GO, with led_go rising the following cycle.
REQ-017 In WAIT, react SHALL enter FALSE next cycle, with false_start=1, digits=0000 and led_go staying 0.
REQ-018 In GO, each ms_tick SHALL increment the 4-digit BCD count with decimal carry (x9 -> (x+1)0, 0999 -> 1000); digits SHALL never hold a value above 9.
REQ-019 In GO, react SHALL enter DONE next cycle and freeze the digits; if react and ms_tick coincide, react SHALL win and that tick SHALL NOT be counted.
REQ-020 In GO, if a tick arrives with the count at 9999, the count SHALL hold at 9999, overflow SHALL go to 1, and the block SHALL enter DONE.
REQ-021 The first count increment SHALL occur exactly CLK_PER_MS cycles after led_go rises.
REQ-022 start SHALL be ignored in WAIT and GO; react SHALL be ignored in IDLE, DONE and FALSE.
REQ-023 If start and react coincide in IDLE, DONE or FALSE, start SHALL take effect and react SHALL be ignored.
REQ-024 Digits and flags SHALL hold their values in DONE and FALSE until the next start or rst.
REQ-025 All outputs SHALL be registered, with no combinational path from start or react to any output.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and SET digits=0000, led_go=0, false_start=0, overflow=0, busy=0, prescaler=0, delay_ms=0 and lfsr=16'hACE1.
REQ-027 rst asserted in any state, including mid-WAIT or mid-GO, SHALL abort the round with no partial result retained.

Verification (bench uses CLK_PER_MS=10, MIN_DELAY_MS=5)
REQ-028 Reset, then start with lfsr[10:0]=3 captured -> busy=1; led_go rises exactly 8x10 cycles after WAIT entry; digits=0000.
REQ-029 react 237 ticks after led_go rises -> DONE; digits 0,2,3,7; led_go=0; busy=0; flags 0; the value holds for 1000 cycles.
REQ-030 react during WAIT -> FALSE; false_start=1; led_go is never high; digits=0000; a following start clears false_start.
REQ-031 No react in GO -> the count passes 0099->0100 and 0999->1000 and saturates at 9999; overflow=1; state DONE.
REQ-032 react coinciding with the 42nd tick -> digits=0041; a second react in DONE and a start during GO are both ignored.
REQ-033 rst pulsed mid-GO at count 0500 -> the next cycle shows IDLE, digits=0000, led_go=0 and lfsr=16'hACE1; a fresh start then completes a normal round.
